pipe_chain: RTL and testbench
=============================

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 Parameter DW, default 32, payload width in bits (1..1024).
REQ-002 Parameter STAGES, default 4, number of register stages (1..16).
REQ-003 Parameter SKID, default 1: 1 = each stage has a skid register and registered ready; 0 = single register per stage with combinational ready.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 valid_i  input  1  upstream data valid.
REQ-007 data_i  input  DW  upstream payload.
REQ-008 ready_o  output  1  block can accept data_i this cycle.
REQ-009 valid_o  output  1  output payload valid.
REQ-010 data_o  output  DW  output payload.
REQ-011 ready_i  input  1  downstream accepts data_o this cycle.
REQ-012 count_o  output  $clog2(CAP+1)  entries currently held. CAP = 2*STAGES if SKID=1, else STAGES.

Function
REQ-013 Input handshake = valid_i && ready_o; output handshake = valid_o && ready_i.
REQ-014 Order is strict FIFO: every accepted word appears on data_o exactly once, in order, with no loss or duplication.
REQ-015 Latency: with ready_i held 1, a word accepted at edge N is presented on valid_o/data_o after edge N+STAGES-1, i.e. STAGES cycles after valid_i was sampled.
REQ-016 Throughput: with ready_i held 1 and valid_i held 1, one word is accepted and one is delivered every cycle in both SKID modes.
REQ-017 While valid_o=1 and ready_i=0, valid_o and data_o hold stable; valid_o never drops without an output handshake.
REQ-018 SKID=1: each stage has main and skid registers. ready into a stage = its skid register is empty, registered (no combinational path from ready_i to ready_o). A word arriving while the stage is stalled goes to the skid register. The skid register drains into the main register before any new word.
REQ-019 SKID=0: stage k is ready when it is empty or stage k+1 is ready. ready_o is combinational from ready_i. Bubbles collapse, and a full chain accepts and delivers in the same cycle when ready_i=1.
REQ-020 Full (count_o=CAP): ready_o=0 (SKID=1), or ready_o=ready_i (SKID=0). valid_i while ready_o=0 is ignored, and data_i is don't-care.
REQ-021 Empty (count_o=0): valid_o=0 and data_o holds its last value.
REQ-022 count_o is registered: +1 on an input handshake only, -1 on an output handshake only, unchanged on both or neither. It never exceeds CAP and never underflows.
REQ-023 Data registers load only on a handshake into them (no toggling on idle cycles).

Reset
REQ-024 While rst_n=1: all stage valid flags and count_o clear to 0, all data registers clear to 0, valid_o=0, data_o=0, and ready_o is forced to 0.
REQ-025 ready_o=1 from the first cycle after rst_n falls.
REQ-026 Reset asserted mid-operation discards all held words immediately. No partial word is emitted afterwards.

Configuration
REQ-027 Macro PIPE_CHAIN_FLUSH_EN: when defined, adds input flush_i (1 bit, active-high, synchronous).
REQ-028 With PIPE_CHAIN_FLUSH_EN and flush_i=1 at an edge:
  - all valid flags and skid registers clear and count_o becomes 0;
  - an input handshake in the same cycle is discarded;
  - an output handshake in the same cycle completes normally;
  - data registers keep their values;
  - ready_o=1 on the next cycle.
REQ-029 Without PIPE_CHAIN_FLUSH_EN: no flush_i port exists, and nothing clears held words except reset.

Verification
REQ-030 Defaults, ready_i=1, send one word 0xA5A5A5A5 -> valid_o=1 with data_o=0xA5A5A5A5 exactly 4 cycles after valid_i sampled, single cycle, count_o back to 0.
REQ-031 Defaults, ready_i=1, 25 back-to-back words 0..24 -> 25 consecutive output cycles, data 0..24 in order, ready_o never 0.
REQ-032 Defaults, ready_i=0, push continuously -> exactly 8 words accepted, then ready_o=0 and count_o=8. Raise ready_i -> 8 words out in order, then the stream continues at 1 word/cycle.
REQ-033 SKID=0, STAGES=3, full chain, ready_i toggles 1/0 each cycle with valid_i=1 -> ready_o equals ready_i combinationally, count_o stays 3, and the data sequence is intact.
REQ-034 Assert rst_n=1 for 2 cycles with 5 words held -> valid_o=0, count_o=0 and ready_o=0 immediately. After release no stale word appears, and a new word 0x1 emerges with normal latency.
REQ-035 PIPE_CHAIN_FLUSH_EN, 6 words held, flush_i=1 for one cycle while valid_i=1 with 0xDEAD -> count_o=0 next cycle, 0xDEAD never output, and ready_o=1.

Source files
------------

// File: rtl/pipe_chain_if.sv
// Valid/ready streaming handshake bundle shared by the producer and consumer sides of pipe_chain.
interface pipe_chain_if #(
  parameter int DW = 32
);
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_chain.sv
// Elastic valid/ready register chain: STAGES stages, each with an optional skid register (SKID=1).
// Optional synchronous flush input is enabled by defining PIPE_CHAIN_FLUSH_EN.
module pipe_chain #(
  parameter  int DW     = 32,
  parameter  int STAGES = 4,
  parameter  int SKID   = 1,
  localparam int CAP    = (SKID != 0) ? 2 * STAGES : STAGES,
  localparam int CW     = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef PIPE_CHAIN_FLUSH_EN
  input  logic          flush_i,
`endif
  pipe_chain_if.slave   in_if,
  pipe_chain_if.master  out_if,
  output logic [CW-1:0] count_o
);

  logic flush;
`ifdef PIPE_CHAIN_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  logic [STAGES-1:0] mv_q, mv_d;
  logic [STAGES-1:0] sv_q, sv_d;
  logic [DW-1:0]     md_q [STAGES];
  logic [DW-1:0]     md_d [STAGES];
  logic [DW-1:0]     sd_q [STAGES];
  logic [DW-1:0]     sd_d [STAGES];
  logic [CW-1:0]     count_q, count_d;

  logic [STAGES:0]   rdy_c;
  logic [STAGES:0]   blk;
  logic [STAGES-1:0] stg_vin;
  logic [STAGES-1:0] stg_rdn;
  logic [DW-1:0]     stg_din [STAGES];
  logic              ready_o;
  logic              in_hs;
  logic              out_hs;

  // blk[k] marks stage k as refusing new words; the top bit is the downstream stall.
  assign blk     = {~out_if.ready, sv_q};
  assign stg_rdn = ~blk[STAGES:1];

  always_comb begin
    rdy_c         = '0;
    rdy_c[STAGES] = out_if.ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy_c[k] = !mv_q[k] || rdy_c[k+1];
    end
    stg_vin = '0;
    for (int k = 0; k < STAGES; k++) begin
      stg_din[k] = '0;
    end
    stg_vin[0] = in_if.valid;
    stg_din[0] = in_if.data;
    for (int k = 1; k < STAGES; k++) begin
      stg_vin[k] = mv_q[k-1];
      stg_din[k] = md_q[k-1];
    end
  end

  // Reset gates ready combinationally so the upstream sees it the moment reset releases.
  assign ready_o     = !rst_n && ((SKID != 0) ? !sv_q[0] : rdy_c[0]);
  assign in_if.ready = ready_o;
  assign in_hs       = in_if.valid && ready_o;
  assign out_hs      = out_if.valid && out_if.ready;

  always_comb begin
    mv_d = mv_q;
    sv_d = sv_q;
    md_d = md_q;
    sd_d = sd_q;
    for (int k = 0; k < STAGES; k++) begin
      if (SKID != 0) begin
        if (sv_q[k]) begin
          if (!mv_q[k] || stg_rdn[k]) begin
            mv_d[k] = 1'b1;
            md_d[k] = sd_q[k];
            sv_d[k] = 1'b0;
          end
        end else if (stg_vin[k]) begin
          if (!mv_q[k] || stg_rdn[k]) begin
            mv_d[k] = 1'b1;
            md_d[k] = stg_din[k];
          end else begin
            sv_d[k] = 1'b1;
            sd_d[k] = stg_din[k];
          end
        end else if (stg_rdn[k]) begin
          mv_d[k] = 1'b0;
        end
      end else if (rdy_c[k]) begin
        mv_d[k] = stg_vin[k];
        if (stg_vin[k]) begin
          md_d[k] = stg_din[k];
        end
      end
    end
    // Flush drops every held word but leaves the payload registers untouched.
    if (flush) begin
      mv_d = '0;
      sv_d = '0;
      md_d = md_q;
      sd_d = sd_q;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_hs && !out_hs) begin
      count_d = count_q + 1'b1;
    end else if (out_hs && !in_hs) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mv_q    <= '0;
      sv_q    <= '0;
      count_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        md_q[k] <= '0;
        sd_q[k] <= '0;
      end
    end else begin
      mv_q    <= mv_d;
      sv_q    <= sv_d;
      count_q <= count_d;
      for (int k = 0; k < STAGES; k++) begin
        md_q[k] <= md_d[k];
        sd_q[k] <= sd_d[k];
      end
    end
  end

  assign out_if.valid = mv_q[STAGES-1];
  assign out_if.data  = md_q[STAGES-1];
  assign count_o      = count_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: a default skid chain and a 3-stage non-skid chain, each scored against a FIFO queue model.
module tb_pipe_chain;
  localparam int A_ST  = 4;
  localparam int A_CAP = 8;
  localparam int B_ST  = 3;
  localparam int B_CAP = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic a_flush, b_flush;
  logic [3:0] a_cnt;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  pipe_chain_if #(.DW(32)) a_in ();
  pipe_chain_if #(.DW(32)) a_out ();
  pipe_chain_if #(.DW(32)) b_in ();
  pipe_chain_if #(.DW(32)) b_out ();

  pipe_chain #(.DW(32), .STAGES(A_ST), .SKID(1)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef PIPE_CHAIN_FLUSH_EN
    .flush_i(a_flush),
`endif
    .in_if  (a_in),
    .out_if (a_out),
    .count_o(a_cnt)
  );

  pipe_chain #(.DW(32), .STAGES(B_ST), .SKID(0)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef PIPE_CHAIN_FLUSH_EN
    .flush_i(b_flush),
`endif
    .in_if  (b_in),
    .out_if (b_out),
    .count_o(b_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference models: plain FIFOs of accepted words.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic        pa_ok = 1'b0, pa_v = 1'b0, pa_r = 1'b0;
  logic [31:0] pa_d = '0;
  logic        pb_ok = 1'b0, pb_v = 1'b0, pb_r = 1'b0;
  logic [31:0] pb_d = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      qa.delete();
      pa_ok = 1'b0;
    end else begin
      chk("a_count", 64'(a_cnt), 64'(qa.size()));
      if (qa.size() == A_CAP) chk("a_full_ready", 64'(a_in.ready), 64'(0));
      if (pa_ok && pa_v && !pa_r) begin
        chk("a_hold_valid", 64'(a_out.valid), 64'(1));
        chk("a_hold_data", 64'(a_out.data), 64'(pa_d));
      end
      if (a_out.valid && a_out.ready) begin
        chk("a_out_nonempty", 64'(qa.size() != 0), 64'(1));
        if (qa.size() != 0) chk("a_data", 64'(a_out.data), 64'(qa.pop_front()));
      end
      pa_ok = !a_flush;
      pa_v  = a_out.valid;
      pa_r  = a_out.ready;
      pa_d  = a_out.data;
      if (a_flush) qa.delete();
      else if (a_in.valid && a_in.ready) qa.push_back(a_in.data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      qb.delete();
      pb_ok = 1'b0;
    end else begin
      chk("b_count", 64'(b_cnt), 64'(qb.size()));
      chk("b_ready_comb", 64'(b_in.ready), 64'((qb.size() < B_CAP) || b_out.ready));
      if (pb_ok && pb_v && !pb_r) begin
        chk("b_hold_valid", 64'(b_out.valid), 64'(1));
        chk("b_hold_data", 64'(b_out.data), 64'(pb_d));
      end
      if (b_out.valid && b_out.ready) begin
        chk("b_out_nonempty", 64'(qb.size() != 0), 64'(1));
        if (qb.size() != 0) chk("b_data", 64'(b_out.data), 64'(qb.pop_front()));
      end
      pb_ok = !b_flush;
      pb_v  = b_out.valid;
      pb_r  = b_out.ready;
      pb_d  = b_out.data;
      if (b_flush) qb.delete();
      else if (b_in.valid && b_in.ready) qb.push_back(b_in.data);
    end
  end

  initial begin
    logic [31:0] outs[$];
    int first, last, acc, drops, saw;
    logic [31:0] seq, seqb;

    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b1;
    a_flush = 1'b0; b_flush = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(a_out.valid), 64'(0));
    chk("rst_data", 64'(a_out.data), 64'(0));
    chk("rst_count", 64'(a_cnt), 64'(0));
    chk("rst_ready", 64'(a_in.ready), 64'(0));
    chk("rst_b_ready", 64'(b_in.ready), 64'(0));
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rel_ready", 64'(a_in.ready), 64'(1));
    chk("rel_b_ready", 64'(b_in.ready), 64'(1));

    // Single word latency.
    a_out.ready = 1'b1;
    tick(); a_in.valid = 1'b1; a_in.data = 32'hA5A5A5A5;
    tick(); a_in.valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lat_valid", 64'(a_out.valid), 64'(i == A_ST - 1));
      if (i == A_ST - 1) chk("lat_data", 64'(a_out.data), 64'(32'hA5A5A5A5));
    end
    chk("lat_count", 64'(a_cnt), 64'(0));

    // Back-to-back stream 0..24.
    first = -1; last = -1; drops = 0;
    for (int c = 0; c < 36; c++) begin
      tick();
      a_in.valid = (c < 25);
      a_in.data  = 32'(c);
      @(negedge clk);
      if (c < 25 && !a_in.ready) drops++;
      if (a_out.valid) begin
        outs.push_back(a_out.data);
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("b2b_drops", 64'(drops), 64'(0));
    chk("b2b_n", 64'(outs.size()), 64'(25));
    chk("b2b_first", 64'(first), 64'(A_ST));
    chk("b2b_span", 64'(last - first), 64'(24));
    for (int i = 0; i < outs.size(); i++) chk("b2b_word", 64'(outs[i]), 64'(i));

    // Fill against a stalled sink, then release.
    a_out.ready = 1'b0; acc = 0; seq = 32'd100;
    for (int c = 0; c < 14; c++) begin
      tick(); a_in.valid = 1'b1; a_in.data = seq;
      @(negedge clk);
      if (a_in.ready) begin acc++; seq++; end
    end
    chk("fill_acc", 64'(acc), 64'(A_CAP));
    chk("fill_ready", 64'(a_in.ready), 64'(0));
    chk("fill_count", 64'(a_cnt), 64'(A_CAP));
    saw = 0;
    for (int c = 0; c < 24; c++) begin
      tick(); a_out.ready = 1'b1; a_in.valid = 1'b1; a_in.data = seq;
      @(negedge clk);
      if (a_in.ready) seq++;
      if (a_out.valid) saw++;
    end
    chk("drain_rate", 64'(saw), 64'(24));
    tick(); a_in.valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("drain_count", 64'(a_cnt), 64'(0));

    // Randomized traffic on both chains.
    for (int c = 0; c < 600; c++) begin
      tick();
      a_in.valid  = ($urandom_range(3) != 0);
      a_in.data   = $urandom;
      a_out.ready = ($urandom_range(2) != 0);
      b_in.valid  = ($urandom_range(3) != 0);
      b_in.data   = $urandom;
      b_out.ready = ($urandom_range(1) != 0);
    end
    tick();
    a_in.valid = 1'b0; a_out.ready = 1'b1; b_in.valid = 1'b0; b_out.ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rand_a_empty", 64'(a_cnt), 64'(0));
    chk("rand_b_empty", 64'(b_cnt), 64'(0));

    // Non-skid chain: full with toggling sink.
    b_out.ready = 1'b0; seqb = 32'd500;
    for (int c = 0; c < 5; c++) begin
      tick(); b_in.valid = 1'b1; b_in.data = seqb;
      @(negedge clk);
      if (b_in.ready) seqb++;
    end
    chk("b_fill", 64'(b_cnt), 64'(B_CAP));
    for (int c = 0; c < 20; c++) begin
      tick(); b_out.ready = (c % 2 == 0); b_in.valid = 1'b1; b_in.data = seqb;
      @(negedge clk);
      chk("b_ready_eq", 64'(b_in.ready), 64'(b_out.ready));
      chk("b_count_full", 64'(b_cnt), 64'(B_CAP));
      if (b_in.ready) seqb++;
    end
    tick(); b_in.valid = 1'b0; b_out.ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("b_drain", 64'(b_cnt), 64'(0));

    // Mid-operation reset with 5 words held.
    a_out.ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); a_in.valid = 1'b1; a_in.data = 32'(200 + c);
    end
    tick(); a_in.valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 64'(a_cnt), 64'(5));
    tick(); rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(a_out.valid), 64'(0));
    chk("mid_rst_count", 64'(a_cnt), 64'(0));
    chk("mid_rst_ready", 64'(a_in.ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    a_out.ready = 1'b1;
    tick(); a_in.valid = 1'b1; a_in.data = 32'h1;
    tick(); a_in.valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(a_out.valid), 64'(i == A_ST - 1));
      if (i == A_ST - 1) chk("post_rst_data", 64'(a_out.data), 64'(1));
    end

`ifdef PIPE_CHAIN_FLUSH_EN
    a_out.ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(); a_in.valid = 1'b1; a_in.data = 32'(300 + c);
    end
    tick(); a_in.valid = 1'b0;
    @(negedge clk);
    chk("pre_flush_count", 64'(a_cnt), 64'(6));
    tick(); a_flush = 1'b1; a_in.valid = 1'b1; a_in.data = 32'hDEAD;
    tick(); a_flush = 1'b0; a_in.valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 64'(a_cnt), 64'(0));
    chk("flush_ready", 64'(a_in.ready), 64'(1));
    a_out.ready = 1'b1; saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_out.valid) saw++;
    end
    chk("flush_no_out", 64'(saw), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
